// File: rtl/i2c_target.sv
// I2C target (slave) with a fixed 7-bit address.
// Supports single- and multi-byte writes and reads, repeated START and STOP.
// SCL/SDA are oversampled on clk_in, which must run at least 16x faster than SCL.
// Ports:
//   clk_in    system clock
//   rst_in    asynchronous active-high reset
//   scl_in    raw SCL line
//   sda_in    raw SDA line
//   sda_oe    1 = pull SDA low, 0 = release it
//   rx_data   last byte written by the controller
//   rx_valid  one-cycle pulse when rx_data updates
//   tx_data   byte to send on the next read byte
//   tx_req    one-cycle pulse in the cycle tx_data is captured
//   busy      high from an address-matched START until STOP or a new START
module i2c_target #(
    parameter logic [6:0] TARGET_ADDR = 7'h42
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic       busy
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ADDR      = 3'd1;
    localparam logic [2:0] S_ADDR_ACK  = 3'd2;
    localparam logic [2:0] S_WRITE     = 3'd3;
    localparam logic [2:0] S_WRITE_ACK = 3'd4;
    localparam logic [2:0] S_READ      = 3'd5;
    localparam logic [2:0] S_READ_ACK  = 3'd6;
    localparam logic [2:0] S_IGNORE    = 3'd7;

    // Two synchronizer flops plus one history flop per line; all reset to the idle-bus level.
    logic scl_s1_q, scl_s2_q, scl_h_q;
    logic sda_s1_q, sda_s2_q, sda_h_q;

    logic [2:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       rw_q, rw_d;
    logic       sda_oe_q, sda_oe_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       tx_req_q, tx_req_d;
    logic       busy_q, busy_d;

    logic scl_rise, scl_fall, start_ev, stop_ev;

    // Events come from the synchronized value and its one-cycle-old copy, so a
    // pin transition becomes an event after two edges and a registered output
    // change on the third.
    assign scl_rise = scl_s2_q & ~scl_h_q;
    assign scl_fall = ~scl_s2_q & scl_h_q;
    assign start_ev = scl_s2_q & scl_h_q & sda_h_q & ~sda_s2_q;
    assign stop_ev  = scl_s2_q & scl_h_q & ~sda_h_q & sda_s2_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        rw_d       = rw_q;
        sda_oe_d   = sda_oe_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        tx_req_d   = 1'b0;
        busy_d     = busy_q;
        if (start_ev) begin
            // Also covers repeated START: busy drops until the address matches again.
            state_d  = S_ADDR;
            cnt_d    = 4'd0;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else if (stop_ev) begin
            state_d  = S_IDLE;
            cnt_d    = 4'd0;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else begin
            case (state_q)
                S_ADDR: begin
                    if (scl_rise && cnt_q < 4'd8) begin
                        shift_d = {shift_q[6:0], sda_s2_q};
                        cnt_d   = cnt_q + 4'd1;
                    end else if (scl_fall && cnt_q == 4'd8) begin
                        if (shift_q[7:1] == TARGET_ADDR) begin
                            state_d  = S_ADDR_ACK;
                            sda_oe_d = 1'b1;
                            busy_d   = 1'b1;
                            rw_d     = shift_q[0];
                        end else begin
                            state_d  = S_IGNORE;
                            sda_oe_d = 1'b0;
                        end
                    end
                end
                S_ADDR_ACK: begin
                    if (scl_fall) begin
                        if (!rw_q) begin
                            state_d  = S_WRITE;
                            cnt_d    = 4'd0;
                            sda_oe_d = 1'b0;
                        end else begin
                            // The MSB goes on the bus now, so it already counts as sent.
                            state_d  = S_READ;
                            shift_d  = tx_data;
                            tx_req_d = 1'b1;
                            sda_oe_d = ~tx_data[7];
                            cnt_d    = 4'd1;
                        end
                    end
                end
                S_WRITE: begin
                    if (scl_rise && cnt_q < 4'd8) begin
                        shift_d = {shift_q[6:0], sda_s2_q};
                        cnt_d   = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            rx_data_d  = {shift_q[6:0], sda_s2_q};
                            rx_valid_d = 1'b1;
                        end
                    end else if (scl_fall && cnt_q == 4'd8) begin
                        state_d  = S_WRITE_ACK;
                        sda_oe_d = 1'b1;
                    end
                end
                S_WRITE_ACK: begin
                    if (scl_fall) begin
                        state_d  = S_WRITE;
                        cnt_d    = 4'd0;
                        sda_oe_d = 1'b0;
                    end
                end
                S_READ: begin
                    if (scl_fall) begin
                        if (cnt_q < 4'd8) begin
                            shift_d  = {shift_q[6:0], 1'b0};
                            sda_oe_d = ~shift_q[6];
                            cnt_d    = cnt_q + 4'd1;
                        end else begin
                            state_d  = S_READ_ACK;
                            sda_oe_d = 1'b0;
                        end
                    end
                end
                S_READ_ACK: begin
                    // The first event here is the ACK-bit rise; a NACK ends the transfer.
                    if (scl_rise && sda_s2_q) begin
                        state_d = S_IGNORE;
                    end else if (scl_fall) begin
                        state_d  = S_READ;
                        shift_d  = tx_data;
                        tx_req_d = 1'b1;
                        sda_oe_d = ~tx_data[7];
                        cnt_d    = 4'd1;
                    end
                end
                default: begin
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            scl_s1_q   <= 1'b1;
            scl_s2_q   <= 1'b1;
            scl_h_q    <= 1'b1;
            sda_s1_q   <= 1'b1;
            sda_s2_q   <= 1'b1;
            sda_h_q    <= 1'b1;
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            shift_q    <= 8'h00;
            rw_q       <= 1'b0;
            sda_oe_q   <= 1'b0;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            tx_req_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            scl_s1_q   <= scl_in;
            scl_s2_q   <= scl_s1_q;
            scl_h_q    <= scl_s2_q;
            sda_s1_q   <= sda_in;
            sda_s2_q   <= sda_s1_q;
            sda_h_q    <= sda_s2_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            rw_q       <= rw_d;
            sda_oe_q   <= sda_oe_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            tx_req_q   <= tx_req_d;
            busy_q     <= busy_d;
        end
    end

    assign sda_oe   = sda_oe_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign tx_req   = tx_req_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: an I2C controller model drives the bus, a wired-AND
// joins controller and target on SDA, and results are compared against a
// directed table, hand-written corner sequences and a transaction-level model.
module tb_i2c_target;

    localparam logic [6:0] ADDR = 7'h42;
    localparam int Q = 8;  // clk cycles per quarter SCL period

    typedef struct {
        logic [7:0]      a8;
        int              n;
        logic [2:0][7:0] d;     // write data, or bytes served on tx_data
        logic            aack;  // expected ACK level for address and write bytes
        int              rx;    // expected rx_valid pulses
        logic [7:0]      rxd;   // expected rx_data afterwards
        int              tx;    // expected tx_req pulses
        logic [2:0][7:0] rd;    // expected bytes seen on a read
        logic            busy;
        logic            oe;
    } vec_t;

    logic       clk, rst, scl, sda_drv, sda_bus;
    logic       sda_oe, rx_valid, tx_req, busy;
    logic [7:0] rx_data, tx_data;
    logic [7:0] tx_bytes [4];
    int         tx_base;
    int         tx_off;
    int         rx_cnt, tx_cnt, oe_cnt, busy_cnt;
    int         n_cmp, n_err;
    logic [7:0] model_rx;

    assign sda_bus = sda_drv & ~sda_oe;

    i2c_target #(.TARGET_ADDR(ADDR)) dut (
        .clk_in  (clk),
        .rst_in  (rst),
        .scl_in  (scl),
        .sda_in  (sda_bus),
        .sda_oe  (sda_oe),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .tx_data (tx_data),
        .tx_req  (tx_req),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The user side: each tx_req advances to the next byte of the current table.
    always_comb begin
        tx_off  = tx_cnt - tx_base;
        tx_data = tx_bytes[tx_off[1:0]];
    end

    always @(negedge clk) begin
        if (rx_valid) rx_cnt <= rx_cnt + 1;
        if (tx_req)   tx_cnt <= tx_cnt + 1;
        if (sda_oe)   oe_cnt <= oe_cnt + 1;
        if (busy)     busy_cnt <= busy_cnt + 1;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic wait_q(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic start_cond();
        sda_drv = 1'b1; wait_q(Q);
        scl = 1'b1;     wait_q(Q);
        sda_drv = 1'b0; wait_q(Q);
        scl = 1'b0;     wait_q(Q);
    endtask

    task automatic stop_cond();
        sda_drv = 1'b0; wait_q(Q);
        scl = 1'b1;     wait_q(Q);
        sda_drv = 1'b1; wait_q(Q);
    endtask

    task automatic write_bit(input logic b);
        sda_drv = b; wait_q(Q);
        scl = 1'b1;  wait_q(2 * Q);
        scl = 1'b0;  wait_q(Q);
    endtask

    task automatic read_bit(output logic b);
        sda_drv = 1'b1; wait_q(Q);
        scl = 1'b1;     wait_q(Q);
        b = sda_bus;    wait_q(Q);
        scl = 1'b0;     wait_q(Q);
    endtask

    task automatic send_byte(input logic [7:0] v, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(v[i]);
        read_bit(ack);
    endtask

    task automatic recv_byte(output logic [7:0] v, input logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            v[i] = b;
        end
        write_bit(ack);
    endtask

    // Transaction-level expectation: a matching address is ACKed, every write byte
    // to it is ACKed and delivered, every read byte returns the user's bytes in
    // order; a foreign address leaves the bus released (all ones) and outputs quiet.
    function automatic vec_t model(input logic [7:0] a8, input int n, input logic [2:0][7:0] d);
        vec_t v;
        logic m;
        m      = (a8[7:1] == ADDR);
        v.a8   = a8;
        v.n    = n;
        v.d    = d;
        v.aack = !m;
        v.busy = m;
        v.oe   = m;
        v.rd   = '0;
        if (!a8[0]) begin
            v.rx  = m ? n : 0;
            v.rxd = m ? d[n-1] : model_rx;
            v.tx  = 0;
        end else begin
            v.rx  = 0;
            v.rxd = model_rx;
            v.tx  = m ? n : 0;
            for (int i = 0; i < n; i++) v.rd[i] = m ? d[i] : 8'hFF;
        end
        return v;
    endfunction

    task automatic apply(input vec_t v, input string tag);
        int r0, t0, o0, b0;
        logic ack;
        logic [7:0] r;
        r0 = rx_cnt; t0 = tx_cnt; o0 = oe_cnt; b0 = busy_cnt;
        tx_base = tx_cnt;
        for (int i = 0; i < 3; i++) tx_bytes[i] = v.d[i];
        tx_bytes[3] = 8'h00;
        start_cond();
        send_byte(v.a8, ack);
        check({tag, ".addr_ack"}, 32'(ack), 32'(v.aack));
        for (int i = 0; i < v.n; i++) begin
            if (!v.a8[0]) begin
                send_byte(v.d[i], ack);
                check($sformatf("%s.data_ack%0d", tag, i), 32'(ack), 32'(v.aack));
            end else begin
                recv_byte(r, (i == v.n - 1));
                check($sformatf("%s.rd%0d", tag, i), 32'(r), 32'(v.rd[i]));
            end
        end
        check({tag, ".oe_end"}, 32'(sda_oe), 32'd0);
        stop_cond();
        wait_q(4);
        check({tag, ".rx_pulses"}, 32'(rx_cnt - r0), 32'(v.rx));
        check({tag, ".rx_data"}, 32'(rx_data), 32'(v.rxd));
        check({tag, ".tx_pulses"}, 32'(tx_cnt - t0), 32'(v.tx));
        check({tag, ".busy_seen"}, 32'(busy_cnt != b0), 32'(v.busy));
        check({tag, ".oe_seen"}, 32'(oe_cnt != o0), 32'(v.oe));
        check({tag, ".busy_after"}, 32'(busy), 32'd0);
        model_rx = v.rxd;
    endtask

    initial begin
        vec_t tbl [4];
        vec_t v;
        logic ack, a1, a2, a3;
        logic [7:0] r;
        logic [7:0] a8;
        logic [2:0][7:0] d;
        int r0, t0, o0;

        rx_cnt = 0; tx_cnt = 0; oe_cnt = 0; busy_cnt = 0;
        n_cmp = 0; n_err = 0; tx_base = 0;
        for (int i = 0; i < 4; i++) tx_bytes[i] = 8'h00;
        model_rx = 8'h00;
        rst = 1'b1; scl = 1'b1; sda_drv = 1'b1;

        tbl[0] = '{a8: 8'h84, n: 1, d: {8'h00, 8'h00, 8'hA5}, aack: 1'b0, rx: 1, rxd: 8'hA5,
                   tx: 0, rd: '0, busy: 1'b1, oe: 1'b1};
        tbl[1] = '{a8: 8'h85, n: 2, d: {8'h00, 8'hC3, 8'h3C}, aack: 1'b0, rx: 0, rxd: 8'hA5,
                   tx: 2, rd: {8'h00, 8'hC3, 8'h3C}, busy: 1'b1, oe: 1'b1};
        tbl[2] = '{a8: 8'h90, n: 1, d: {8'h00, 8'h00, 8'hFF}, aack: 1'b1, rx: 0, rxd: 8'hA5,
                   tx: 0, rd: '0, busy: 1'b0, oe: 1'b0};
        tbl[3] = '{a8: 8'h84, n: 2, d: {8'h00, 8'h7E, 8'h00}, aack: 1'b0, rx: 2, rxd: 8'h7E,
                   tx: 0, rd: '0, busy: 1'b1, oe: 1'b1};

        // Reset state
        wait_q(5);
        check("rst.sda_oe", 32'(sda_oe), 32'd0);
        check("rst.rx_data", 32'(rx_data), 32'd0);
        check("rst.rx_valid", 32'(rx_valid), 32'd0);
        check("rst.tx_req", 32'(tx_req), 32'd0);
        check("rst.busy", 32'(busy), 32'd0);
        rst = 1'b0;
        wait_q(4);

        // Address ACK appears on exactly the third clk edge after the SCL fall
        a8 = 8'h84;
        start_cond();
        for (int i = 7; i >= 1; i--) write_bit(a8[i]);
        sda_drv = 1'b0; wait_q(Q);
        scl = 1'b1;     wait_q(2 * Q);
        scl = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        check("lat.edge2", 32'(sda_oe), 32'd0);
        @(posedge clk); #1;
        check("lat.edge3", 32'(sda_oe), 32'd1);
        wait_q(Q - 3);
        read_bit(ack);
        check("lat.ack", 32'(ack), 32'd0);
        stop_cond();
        wait_q(4);
        check("lat.busy_after", 32'(busy), 32'd0);

        for (int i = 0; i < 4; i++) apply(tbl[i], $sformatf("tbl%0d", i));

        // Early STOP during bit 4 of a write byte
        r0 = rx_cnt;
        start_cond();
        send_byte(8'h84, ack);
        check("estop.addr_ack", 32'(ack), 32'd0);
        write_bit(1'b1); write_bit(1'b0); write_bit(1'b1);
        sda_drv = 1'b0; wait_q(Q);
        scl = 1'b1;     wait_q(Q);
        sda_drv = 1'b1; wait_q(Q);
        check("estop.rx_pulses", 32'(rx_cnt - r0), 32'd0);
        check("estop.sda_oe", 32'(sda_oe), 32'd0);
        check("estop.busy", 32'(busy), 32'd0);
        scl = 1'b0; wait_q(Q);
        send_byte(8'h84, ack);
        check("estop.idle_no_ack", 32'(ack), 32'd1);
        stop_cond();
        wait_q(4);

        // Repeated START: write 0x11, then read one byte and NACK it
        r0 = rx_cnt; t0 = tx_cnt;
        tx_base = tx_cnt;
        tx_bytes[0] = 8'h9B;
        start_cond();
        send_byte(8'h84, a1);
        send_byte(8'h11, a2);
        start_cond();
        send_byte(8'h85, a3);
        recv_byte(r, 1'b1);
        check("rs.oe_after_nack", 32'(sda_oe), 32'd0);
        stop_cond();
        wait_q(4);
        check("rs.ack_w", 32'(a1), 32'd0);
        check("rs.ack_d", 32'(a2), 32'd0);
        check("rs.ack_r", 32'(a3), 32'd0);
        check("rs.rx_data", 32'(rx_data), 32'h11);
        check("rs.rx_pulses", 32'(rx_cnt - r0), 32'd1);
        check("rs.tx_pulses", 32'(tx_cnt - t0), 32'd1);
        check("rs.rd", 32'(r), 32'h9B);
        check("rs.busy_after", 32'(busy), 32'd0);

        // Reset while the target is driving a read bit low
        tx_base = tx_cnt;
        tx_bytes[0] = 8'h00;
        start_cond();
        send_byte(8'h85, ack);
        check("rrst.addr_ack", 32'(ack), 32'd0);
        check("rrst.driving", 32'(sda_oe), 32'd1);
        rst = 1'b1;
        #1;
        check("rrst.sda_oe", 32'(sda_oe), 32'd0);
        check("rrst.rx_data", 32'(rx_data), 32'd0);
        check("rrst.rx_valid", 32'(rx_valid), 32'd0);
        check("rrst.tx_req", 32'(tx_req), 32'd0);
        check("rrst.busy", 32'(busy), 32'd0);
        wait_q(3);
        rst = 1'b0;
        model_rx = 8'h00;
        wait_q(2);
        scl = 1'b1; wait_q(Q);
        sda_drv = 1'b1; wait_q(Q);
        // Bits clocked without a START are ignored
        o0 = oe_cnt;
        scl = 1'b0; wait_q(Q);
        send_byte(8'h84, ack);
        check("rrst.no_start_ack", 32'(ack), 32'd1);
        check("rrst.no_start_oe", 32'(oe_cnt != o0), 32'd0);
        stop_cond();
        wait_q(4);
        d = {8'h00, 8'h00, 8'h5A};
        apply(model(8'h84, 1, d), "rrst.fresh");

        // Random transactions against the transaction-level model
        for (int k = 0; k < 20; k++) begin
            logic [6:0] a7;
            int n;
            if ($urandom_range(0, 1) == 1) a7 = ADDR;
            else begin
                a7 = 7'($urandom_range(0, 127));
                if (a7 == ADDR) a7 = a7 ^ 7'h01;
            end
            n = $urandom_range(1, 3);
            for (int i = 0; i < 3; i++) d[i] = 8'($urandom_range(0, 255));
            v = model({a7, 1'($urandom_range(0, 1))}, n, d);
            apply(v, $sformatf("rnd%0d", k));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
